// File: rtl/boid_pkg.sv
// Shared types and constants for the boid frame scheduler and its memory port mux.
package boid_pkg;

  // Scheduler FSM encoding; exported on state_o for debug.
  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_WAIT_VS = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3
  } state_e;

  // Host writes update x, y, vx, vy and the valid bit together.
  localparam logic [6:0] WB_ALL = 7'b0011111;

  // Boid state is fixed point with 16 fractional bits.
  localparam int FIX_FRAC = 16;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] vx;
    logic signed [31:0] vy;
  } boid_state_t;

endpackage

// File: rtl/boid_mem_port_mux.sv
// 2:1 selector for the boid memory write port (host loader vs xcel datapath).
// Any write aimed at a slot beyond NUM_BOIDS is suppressed.
module boid_mem_port_mux
  import boid_pkg::*;
#(
  parameter int NUM_BOIDS = 2,
  parameter int BW        = $clog2(NUM_BOIDS) + 1
) (
  input  logic              sel_host_i,
  input  logic [BW-1:0]     host_boid_i,
  input  logic [6:0]        host_wb_en_i,
  input  boid_state_t       host_data_i,
  input  logic [BW-1:0]     xcel_boid_i,
  input  logic [6:0]        xcel_wb_en_i,
  input  boid_state_t       xcel_data_i,
  output logic [BW-1:0]     mem_boid_o,
  output logic [6:0]        mem_wb_en_o,
  output boid_state_t       mem_data_o
);

  localparam logic [BW-1:0] NB = BW'(NUM_BOIDS);

  // Select the owning path and gate out-of-range writes.
  always_comb begin
    mem_boid_o  = sel_host_i ? host_boid_i  : xcel_boid_i;
    mem_data_o  = sel_host_i ? host_data_i  : xcel_data_i;
    mem_wb_en_o = sel_host_i ? host_wb_en_i : xcel_wb_en_i;
    if (mem_boid_o >= NB) mem_wb_en_o = 7'd0;
  end

endmodule

// File: rtl/boid_frame_sched.sv
// Frame scheduler: owns the boid memory write port, starts one accelerator
// update every FRAME_DIV vsync edges and watches for completion or timeout.
module boid_frame_sched
  import boid_pkg::*;
#(
  parameter  int NUM_BOIDS = 2,
  parameter  int FRAME_DIV = 1,
  parameter  int TIMEOUT   = 4096,
  localparam int BW        = $clog2(NUM_BOIDS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_go,
  input  logic          host_wr_req,
  input  logic [BW-1:0] host_boid,
  input  logic [31:0]   host_x,
  input  logic [31:0]   host_y,
  input  logic [31:0]   host_vx,
  input  logic [31:0]   host_vy,
  output logic          host_wr_ack,
  input  logic          vsync,
  input  logic          xcel_done,
  output logic          xcel_en,
  input  logic [BW-1:0] xcel_which_boid,
  input  logic [6:0]    xcel_wb_en,
  input  logic [31:0]   xcel_x,
  input  logic [31:0]   xcel_y,
  input  logic [31:0]   xcel_vx,
  input  logic [31:0]   xcel_vy,
  output logic [BW-1:0] mem_which_boid,
  output logic [6:0]    mem_wb_en,
  output logic [31:0]   mem_x,
  output logic [31:0]   mem_y,
  output logic [31:0]   mem_vx,
  output logic [31:0]   mem_vy,
  output logic [15:0]   frame_cnt,
  output logic          err_timeout,
  output logic          err_overrun,
  output logic          err_range,
  output logic [2:0]    state_o
);

  localparam int            TW       = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]   DIV_LAST = 16'(FRAME_DIV - 1);
  localparam logic [BW-1:0] NB       = BW'(NUM_BOIDS);

  state_e        state_q, state_d;
  logic          host_ack_q, host_ack_d;
  logic          vsync_q;
  logic [15:0]   div_q, div_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   frame_q, frame_d;
  logic          err_tmo_q, err_tmo_d;
  logic          err_ovr_q, err_ovr_d;
  logic          err_rng_q, err_rng_d;

  logic          vs_edge;
  logic          host_fire;
  logic          sel_host;
  logic [6:0]    host_wb;
  boid_state_t   host_data, xcel_data, mem_data;

  assign vs_edge   = vsync & ~vsync_q;
  // Reset forces the port back to the host side with writes disabled and
  // holds the controller idle, even before the state register clears.
  assign host_fire = (state_q == S_LOAD) && host_wr_req && !host_ack_q && !reset;
  assign sel_host  = (state_q == S_LOAD) || reset;
  assign host_wb   = host_fire ? WB_ALL : 7'd0;
  assign xcel_en   = !((state_q == S_START) && !reset);

  assign host_data = {host_x, host_y, host_vx, host_vy};
  assign xcel_data = {xcel_x, xcel_y, xcel_vx, xcel_vy};

  boid_mem_port_mux #(
    .NUM_BOIDS (NUM_BOIDS),
    .BW        (BW)
  ) u_mux (
    .sel_host_i   (sel_host),
    .host_boid_i  (host_boid),
    .host_wb_en_i (host_wb),
    .host_data_i  (host_data),
    .xcel_boid_i  (xcel_which_boid),
    .xcel_wb_en_i (xcel_wb_en),
    .xcel_data_i  (xcel_data),
    .mem_boid_o   (mem_which_boid),
    .mem_wb_en_o  (mem_wb_en),
    .mem_data_o   (mem_data)
  );

  assign mem_x       = mem_data.x;
  assign mem_y       = mem_data.y;
  assign mem_vx      = mem_data.vx;
  assign mem_vy      = mem_data.vy;
  assign host_wr_ack = host_ack_q;
  assign frame_cnt   = frame_q;
  assign err_timeout = err_tmo_q;
  assign err_overrun = err_ovr_q;
  assign err_range   = err_rng_q;
  assign state_o     = state_q;

  // Next-state logic for the frame FSM, counters and sticky error flags.
  always_comb begin
    state_d    = state_q;
    host_ack_d = 1'b0;
    div_d      = div_q;
    tmo_d      = tmo_q;
    frame_d    = frame_q;
    err_tmo_d  = err_tmo_q;
    err_ovr_d  = err_ovr_q;
    err_rng_d  = err_rng_q;
    case (state_q)
      S_LOAD: begin
        host_ack_d = host_fire;
        div_d      = 16'd0;
        if (host_fire && (host_boid >= NB)) err_rng_d = 1'b1;
        if (host_go && !host_wr_req) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (!host_go) begin
          state_d = S_LOAD;
        end else if (vs_edge) begin
          if (div_q == DIV_LAST) begin
            state_d = S_START;
            div_d   = 16'd0;
          end else begin
            div_d = div_q + 16'd1;
          end
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        tmo_d = tmo_q + TW'(1);
        // A vsync during an update means the frame budget was missed.
        if (vs_edge) err_ovr_d = 1'b1;
        // Completion takes priority over a simultaneous timeout.
        if (xcel_done) begin
          frame_d = frame_q + 16'd1;
          state_d = host_go ? S_WAIT_VS : S_LOAD;
        end else if (tmo_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          state_d   = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    vsync_q <= vsync;
    if (reset) begin
      state_q    <= S_LOAD;
      host_ack_q <= 1'b0;
      div_q      <= 16'd0;
      tmo_q      <= '0;
      frame_q    <= 16'd0;
      err_tmo_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      err_rng_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      host_ack_q <= host_ack_d;
      div_q      <= div_d;
      tmo_q      <= tmo_d;
      frame_q    <= frame_d;
      err_tmo_q  <= err_tmo_d;
      err_ovr_q  <= err_ovr_d;
      err_rng_q  <= err_rng_d;
    end
  end

endmodule

// File: tb/tb_boid_frame_sched.sv
// Bench for boid_frame_sched: host load, frame pacing, timeout, overrun,
// stop/range handling and mid-frame reset, with a stub xcel controller.
module tb_boid_frame_sched;
  import boid_pkg::*;

  localparam int NB = 2;
  localparam int BW = $clog2(NB) + 1;

  logic          clk = 1'b0;
  logic          reset, host_go, host_wr_req, vsync, xcel_done;
  logic [BW-1:0] host_boid, xcel_which_boid, mem_which_boid;
  logic [31:0]   host_x, host_y, host_vx, host_vy;
  logic [31:0]   xcel_x, xcel_y, xcel_vx, xcel_vy;
  logic [31:0]   mem_x, mem_y, mem_vx, mem_vy;
  logic [6:0]    xcel_wb_en, mem_wb_en;
  logic          host_wr_ack, xcel_en, err_timeout, err_overrun, err_range;
  logic [15:0]   frame_cnt;
  logic [2:0]    state_o;

  typedef struct {
    logic [BW-1:0] b;
    boid_state_t   d;
  } wr_exp_t;

  wr_exp_t     exp_q[$];
  boid_state_t mem_m [NB];
  int checks = 0;
  int fails  = 0;
  int starts = 0;
  int width_err = 0;
  int done_dly = 0;
  int cd = 0;
  bit prev_low = 0;

  always #5 clk = ~clk;

  boid_frame_sched #(.NUM_BOIDS(NB), .FRAME_DIV(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .host_go(host_go), .host_wr_req(host_wr_req),
    .host_boid(host_boid), .host_x(host_x), .host_y(host_y), .host_vx(host_vx),
    .host_vy(host_vy), .host_wr_ack(host_wr_ack), .vsync(vsync),
    .xcel_done(xcel_done), .xcel_en(xcel_en), .xcel_which_boid(xcel_which_boid),
    .xcel_wb_en(xcel_wb_en), .xcel_x(xcel_x), .xcel_y(xcel_y), .xcel_vx(xcel_vx),
    .xcel_vy(xcel_vy), .mem_which_boid(mem_which_boid), .mem_wb_en(mem_wb_en),
    .mem_x(mem_x), .mem_y(mem_y), .mem_vx(mem_vx), .mem_vy(mem_vy),
    .frame_cnt(frame_cnt), .err_timeout(err_timeout), .err_overrun(err_overrun),
    .err_range(err_range), .state_o(state_o)
  );

  // Behavioural boid memory fed by the scheduler's write port.
  always @(posedge clk) begin
    if (mem_wb_en == WB_ALL && mem_which_boid < BW'(NB))
      mem_m[mem_which_boid] <= {mem_x, mem_y, mem_vx, mem_vy};
  end

  // Stub controller: counts start pulses, flags wide ones, answers after done_dly.
  initial begin
    xcel_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      xcel_done = 1'b0;
      if (xcel_en === 1'b0) begin
        starts++;
        if (prev_low) width_err++;
        prev_low = 1'b1;
        cd = done_dly;
      end else begin
        prev_low = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) xcel_done = 1'b1;
        end
      end
    end
  end

  task automatic vs_pulse(input int gap);
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_start();
    int n = 0;
    while (xcel_en !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; fails++;
      $display("FAIL start_wait: no start pulse within %0d cycles, required one", n);
    end
  endtask

  task automatic host_write(input logic [BW-1:0] b, input boid_state_t d, input bit in_range);
    int wbc = 0, wb_i = -1, ack_i = -1;
    bit acked = 0;
    wr_exp_t e;
    boid_state_t mo;
    @(negedge clk);
    host_boid = b; host_x = d.x; host_y = d.y; host_vx = d.vx; host_vy = d.vy;
    host_wr_req = 1'b1;
    if (in_range) exp_q.push_back('{b, d});
    for (int i = 0; i < 10 && !acked; i++) begin
      #1;
      if (host_wr_ack === 1'b1) begin
        acked = 1; ack_i = i;
      end
      if (mem_wb_en !== 7'd0) begin
        wbc++; wb_i = i;
        checks++;
        mo = {mem_x, mem_y, mem_vx, mem_vy};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: wb_en=%b boid=%0d, required no write", mem_wb_en, mem_which_boid);
        end else begin
          e = exp_q.pop_front();
          if (mem_wb_en !== WB_ALL || mem_which_boid !== e.b || mo !== e.d) begin
            fails++;
            $display("FAIL wr_data: wb=%b idx=%0d data=%h, required wb=%b idx=%0d data=%h",
                     mem_wb_en, mem_which_boid, mo, WB_ALL, e.b, e.d);
          end
        end
      end
      if (!acked) @(negedge clk);
    end
    host_wr_req = 1'b0;
    checks++;
    if (!acked) begin
      fails++; $display("FAIL wr_ack: ack not seen, required pulse");
    end
    checks++;
    if (wbc !== (in_range ? 1 : 0)) begin
      fails++; $display("FAIL wr_wb_cycles: %0d write cycles, required %0d", wbc, in_range ? 1 : 0);
    end
    if (in_range) begin
      checks++;
      if (ack_i - wb_i !== 1) begin
        fails++; $display("FAIL wr_ack_lat: ack %0d cycles after write, required 1", ack_i - wb_i);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; host_go = 0; host_wr_req = 0; vsync = 0;
    host_boid = '0; host_x = 0; host_y = 0; host_vx = 0; host_vy = 0;
    xcel_which_boid = '0; xcel_wb_en = 7'd0;
    xcel_x = 0; xcel_y = 0; xcel_vx = 0; xcel_vy = 0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 3'd0 || xcel_en !== 1'b1 || host_wr_ack !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl: state=%0d xcel_en=%b ack=%b, required 0 1 0", state_o, xcel_en, host_wr_ack);
    end
    checks++;
    if (frame_cnt !== 16'd0 || {err_timeout, err_overrun, err_range} !== 3'b000) begin
      fails++; $display("FAIL reset_cnt: frame=%0d errs=%b, required 0 000", frame_cnt, {err_timeout, err_overrun, err_range});
    end
    checks++;
    if (mem_wb_en !== 7'd0) begin
      fails++; $display("FAIL reset_wb: wb_en=%b, required 0", mem_wb_en);
    end
  endtask

  task automatic test_load();
    boid_state_t b0, b1;
    b0 = {32'h013190ff, 32'h00e94929, 32'h0003d134, 32'h00011162};
    b1 = {32'h015f941f, 32'h00ffe497, 32'h00041d66, 32'hfffffaac};
    host_write(2'd0, b0, 1'b1);
    host_write(2'd1, b1, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_m[0] !== b0) begin fails++; $display("FAIL load_rb0: %h, required %h", mem_m[0], b0); end
    checks++;
    if (mem_m[1] !== b1) begin fails++; $display("FAIL load_rb1: %h, required %h", mem_m[1], b1); end
  endtask

  task automatic test_run();
    int s0;
    done_dly = 20;
    host_go = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (state_o !== 3'd1) begin fails++; $display("FAIL run_wait: state=%0d, required 1", state_o); end
    s0 = starts;
    for (int i = 0; i < 4; i++) vs_pulse(40);
    checks++;
    if (starts - s0 !== 2) begin fails++; $display("FAIL run_starts: %0d starts, required 2", starts - s0); end
    checks++;
    if (width_err !== 0) begin fails++; $display("FAIL run_width: %0d wide start pulses, required 0", width_err); end
    checks++;
    if (frame_cnt !== 16'd2) begin fails++; $display("FAIL run_frames: %0d, required 2", frame_cnt); end
  endtask

  task automatic test_timeout();
    int n = 0;
    done_dly = 0;
    vs_pulse(5); vs_pulse(0);
    wait_start();
    while (state_o !== 3'd0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n < 64 || n > 65) begin fails++; $display("FAIL tmo_latency: %0d cycles to LOAD, required 64..65", n); end
    checks++;
    if (err_timeout !== 1'b1) begin fails++; $display("FAIL tmo_flag: %b, required 1", err_timeout); end
    checks++;
    if (frame_cnt !== 16'd2) begin fails++; $display("FAIL tmo_frames: %0d, required 2", frame_cnt); end
    done_dly = 20;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun();
    int s0;
    checks++;
    if (err_overrun !== 1'b0) begin fails++; $display("FAIL ovr_pre: %b, required 0", err_overrun); end
    vs_pulse(5); vs_pulse(0);
    wait_start();
    repeat (10) @(negedge clk);
    vs_pulse(30);
    checks++;
    if (err_overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: %b, required 1", err_overrun); end
    checks++;
    if (frame_cnt !== 16'd3) begin fails++; $display("FAIL ovr_frames: %0d, required 3", frame_cnt); end
    s0 = starts;
    vs_pulse(40);
    checks++;
    if (starts !== s0) begin fails++; $display("FAIL ovr_notcounted: %0d starts, required 0", starts - s0); end
    vs_pulse(40);
    checks++;
    if (starts - s0 !== 1) begin fails++; $display("FAIL ovr_next: %0d starts, required 1", starts - s0); end
    checks++;
    if (frame_cnt !== 16'd4) begin fails++; $display("FAIL ovr_frames2: %0d, required 4", frame_cnt); end
  endtask

  task automatic test_stop_range();
    int n = 0;
    boid_state_t bx;
    vs_pulse(5); vs_pulse(0);
    wait_start();
    repeat (5) @(negedge clk);
    host_go = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (state_o !== 3'd3) begin fails++; $display("FAIL stop_hold: state=%0d, required 3", state_o); end
    while (state_o !== 3'd0 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (state_o !== 3'd0 || frame_cnt !== 16'd5) begin
      fails++; $display("FAIL stop_load: state=%0d frame=%0d, required 0 5", state_o, frame_cnt);
    end
    checks++;
    if (err_range !== 1'b0) begin fails++; $display("FAIL range_pre: %b, required 0", err_range); end
    bx = {32'h1, 32'h2, 32'h3, 32'h4};
    host_write(2'd2, bx, 1'b0);
    checks++;
    if (err_range !== 1'b1) begin fails++; $display("FAIL range_flag: %b, required 1", err_range); end
  endtask

  task automatic test_reset_run();
    host_go = 1'b1;
    @(negedge clk);
    vs_pulse(5); vs_pulse(0);
    wait_start();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (xcel_en !== 1'b1 || mem_wb_en !== 7'd0) begin
      fails++; $display("FAIL rst_comb: xcel_en=%b wb=%b, required 1 0", xcel_en, mem_wb_en);
    end
    @(negedge clk);
    checks++;
    if (xcel_en !== 1'b1 || state_o !== 3'd0 || frame_cnt !== 16'd0) begin
      fails++; $display("FAIL rst_run: xcel_en=%b state=%0d frame=%0d, required 1 0 0", xcel_en, state_o, frame_cnt);
    end
    checks++;
    if ({err_timeout, err_overrun, err_range} !== 3'b000) begin
      fails++; $display("FAIL rst_errs: %b, required 000", {err_timeout, err_overrun, err_range});
    end
    host_go = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_timeout();
    test_overrun();
    test_stop_range();
    test_reset_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/boid_frame_sched.md
Name: boid_frame_sched

Overview:
- Frame-level scheduler and boid-memory port arbiter for the boid accelerator.
- Owns the write port of the boid register memory. In LOAD the host loader owns it; in RUN the xcel datapath/controller owns it.
- Issues one start pulse to the accelerator controller per N VGA frames and waits for its completion pulse.
- Sits between the HPS/host loader, the xcel controller/datapath pair, and the boid register memory wrapper.

Parameters:
- NUM_BOIDS, 2, number of boid slots in memory.
- FRAME_DIV, 1, run one update every FRAME_DIV vsync rising edges (FRAME_DIV >= 1).
- TIMEOUT, 4096, max cycles from start pulse to xcel_done before abort.
- BW, $clog2(NUM_BOIDS)+1, boid index width (localparam).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- host_go  in  1  level; 1 = run simulation, 0 = return to LOAD after the current frame.
- host_wr_req  in  1  host write request; held until ack.
- host_boid  in  BW  target boid index.
- host_x, host_y, host_vx, host_vy  in  32 each  fixed-point (16 fractional bits) boid state.
- host_wr_ack  out  1  one-cycle pulse; write accepted.
- vsync  in  1  VGA vertical sync, same clock domain, active high.
- xcel_done  in  1  one-cycle pulse from xcel controller; last writeback finished.
- xcel_en  out  1  controller start; idle 1, driven 0 for exactly one cycle to start a frame.
- xcel_which_boid  in  BW  controller boid index.
- xcel_wb_en  in  7  controller writeback enables.
- xcel_x, xcel_y, xcel_vx, xcel_vy  in  32 each  datapath writeback data.
- mem_which_boid  out  BW  to memory.
- mem_wb_en  out  7  to memory.
- mem_x, mem_y, mem_vx, mem_vy  out  32 each  to memory.
- frame_cnt  out  16  completed frames; wraps at 16'hFFFF -> 0.
- err_timeout, err_overrun, err_range  out  1 each  sticky error flags.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset values: state = S_LOAD, xcel_en = 1, host_wr_ack = 0, frame_cnt = 0, all err flags = 0, vsync divider = 0, timeout counter = 0.
- Reset asserted mid-frame aborts immediately; the controller sees xcel_en = 1 and the memory sees host mux with wb_en = 0.
- States:
  - S_LOAD: memory port driven by the host path. A cycle with host_wr_req = 1 and host_ack_q = 0 writes mem_wb_en = 7'b0011111 with host data and index, combinationally. The ack is registered and pulses the next cycle, so one write occupies 2 cycles. With no request, mem_wb_en = 0.
  - LOAD -> S_WAIT_VS when host_go = 1 and host_wr_req = 0.
  - S_WAIT_VS: memory mux selects the xcel path. Count vsync rising edges (vsync & ~vsync_q). On edge number FRAME_DIV, go to S_START and clear the divider. If host_go = 0, go to S_LOAD.
  - S_START: xcel_en = 0 for this single cycle, timeout counter cleared, go to S_RUN.
  - S_RUN: xcel path owns memory, passed through combinationally.
    - On xcel_done: frame_cnt += 1. Next state is S_LOAD if host_go = 0, else S_WAIT_VS.
    - If the timeout counter reaches TIMEOUT-1 without xcel_done: set err_timeout and go to S_LOAD.
    - A vsync rising edge seen in S_RUN sets err_overrun and is not counted.
  - xcel_done in the same cycle as timeout expiry: done wins; frame counted, no error.
- Host requests outside S_LOAD are not acked; they stall until LOAD is re-entered.
- host_boid >= NUM_BOIDS: acked normally, mem_wb_en forced to 0, err_range set.
- xcel_done outside S_RUN is ignored.
- Error flags clear only on reset.

Decomposition:
- Shared package boid_pkg holds:
  - state enum (S_LOAD = 0, S_WAIT_VS, S_START, S_RUN);
  - WB_ALL = 7'b0011111;
  - FIX_FRAC = 16;
  - a boid_state_t struct of x/y/vx/vy.
- One sub-module, boid_mem_port_mux: pure 2:1 selection of index, wb_en and data with range gating. The FSM, counters and vsync edge detection stay in the top.

Test Plan:
- Load: reset 100 ns. Write boid 0 = {013190ff, 00e94929, 0003d134, 00011162} and boid 1 = {015f941f, 00ffe497, 00041d66, fffffaac}. Expect mem_wb_en = 7'b0011111 for exactly 1 cycle each and host_wr_ack 1 cycle later; memory readback matches.
- Run with FRAME_DIV = 2: host_go = 1, 4 vsync pulses, stub controller returns xcel_done 20 cycles after start. Expect exactly 2 xcel_en low pulses, each 1 cycle wide, and frame_cnt = 2.
- Timeout with TIMEOUT = 64: xcel_done never asserted. Expect return to S_LOAD 64 cycles after the start pulse, err_timeout = 1, frame_cnt unchanged.
- Overrun: vsync edge 10 cycles into S_RUN. Expect err_overrun = 1, the frame still completes, and the next start is not triggered by that edge.
- Stop and range: drop host_go mid-S_RUN; expect S_LOAD only after xcel_done. Then write host_boid = 2 (NUM_BOIDS = 2); expect ack, mem_wb_en = 0, err_range = 1.
- Reset mid-S_RUN: expect xcel_en = 1, state_o = S_LOAD and frame_cnt = 0 on the next cycle.
